regfile_bypass: RTL and testbench
=================================

REGFILE_BYPASS -- requirements
Module: regfile_bypass

Interface
REQ-001 Parameter DATA_W, default 32, width of every register and data port.
REQ-002 Parameter ADDR_W, default 5, index width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 0; 1 = register 0 hardwired to zero.
REQ-004 Parameter LINK_INDEX, default DEPTH-1, target of link writes.
REQ-005 Parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding enabled.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 reg1_index  input  ADDR_W  read port 1 index, also write index for mode 2'b10.
REQ-009 reg2_index  input  ADDR_W  read port 2 index, also write index for mode 2'b11.
REQ-010 reg_write  input  2  write mode: 00 none, 10 write reg1_index, 01 write LINK_INDEX, 11 write reg2_index.
REQ-011 data_write  input  DATA_W  write data.
REQ-012 show_index  input  ADDR_W  debug read index.
REQ-013 clr_req  input  1  single-cycle request to start background clear.
REQ-014 reg1_value  output  DATA_W  read port 1 data, combinational.
REQ-015 reg2_value  output  DATA_W  read port 2 data, combinational.
REQ-016 reg_return  output  DATA_W  debug read data, combinational, never bypassed.
REQ-017 busy  output  1  high while clear FSM is in CLEAR.
REQ-018 clr_done  output  1  one-cycle pulse on final clear step.
REQ-019 wr_drop  output  1  registered one-cycle pulse when a write is discarded due to busy.

Function
REQ-020 Write target index = reg1_index (10), LINK_INDEX (01), reg2_index (11); mode 00 writes nothing.
REQ-021 In IDLE a valid write updates the target register at the rising edge; latency to stored value 1 cycle.
REQ-022 ZERO_REG=1: writes targeting index 0 are discarded silently (no wr_drop); all reads of index 0 return 0.
REQ-023 BYPASS=1, state IDLE, write active, read index equals write target (and not zero-reg index 0): that read port returns data_write in the same cycle.
REQ-024 Reads otherwise return stored array contents; reg_return always returns stored contents.
REQ-025 FSM states IDLE, CLEAR; reset state IDLE.
REQ-026 IDLE and clr_req=1 -> CLEAR next cycle with clear pointer = 0.
REQ-027 In CLEAR each cycle: register[pointer] <= 0, pointer increments by 1.
REQ-028 CLEAR with pointer = DEPTH-1: clears last register, clr_done=1 that cycle (combinational from state and pointer), -> IDLE next cycle; full clear takes exactly DEPTH cycles.
REQ-029 clr_req while in CLEAR is ignored; pointer does not restart.
REQ-030 In CLEAR any write with reg_write != 00 is discarded; wr_drop = 1 in the following cycle for exactly one cycle per discarded write.
REQ-031 In CLEAR no bypass; reads return stored contents (mix of cleared/uncleared registers).
REQ-032 clr_req and a valid write in the same IDLE cycle: write is performed, then clear starts next cycle and zeroes it.
REQ-033 Pointer width ADDR_W; no wrap beyond DEPTH-1.

Reset
REQ-034 rst=1 asynchronously zeroes all DEPTH registers, pointer=0, state=IDLE, wr_drop=0, independent of clk.
REQ-035 While rst=1: busy=0, clr_done=0, wr_drop=0, read outputs return 0.
REQ-036 rst asserted mid-CLEAR aborts clear; after release FSM is IDLE, no clr_done pulse.

Verification
REQ-037 Write 32'hDEADBEEF mode 10 index 5; same cycle read reg1_index=5 -> reg1_value=32'hDEADBEEF (bypass); next cycle reg_return(show 5)=32'hDEADBEEF.
REQ-038 Mode 01 data 32'h00001234 -> register LINK_INDEX (31) = 32'h00001234; ZERO_REG=1 write 32'hFFFFFFFF to index 0 -> reads 0, wr_drop stays 0.
REQ-039 Fill all registers nonzero, pulse clr_req -> busy high exactly 32 cycles, clr_done on 32nd, all registers 0 afterwards.
REQ-040 During CLEAR issue mode 11 write to index 30 -> write discarded, wr_drop pulses one cycle, register 30 reads 0 after clear.
REQ-041 Assert rst asynchronously at clear pointer 10 -> all outputs 0 immediately, IDLE after release, no clr_done.
REQ-042 BYPASS=0 build: write 32'hA5A5A5A5 index 3 with reg2_index=3 -> reg2_value shows old value that cycle, new value next cycle.

Source files
------------

// File: rtl/regfile_bypass.sv
// Multi-mode register file with same-cycle write forwarding and a background
// clear engine that zeroes one register per cycle while dropping writes.
module regfile_bypass #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int ZERO_REG   = 0,
    parameter int LINK_INDEX = (2 ** ADDR_W) - 1,
    parameter int BYPASS     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] reg1_index,
    input  logic [ADDR_W-1:0] reg2_index,
    input  logic [1:0]        reg_write,
    input  logic [DATA_W-1:0] data_write,
    input  logic [ADDR_W-1:0] show_index,
    input  logic              clr_req,
    output logic [DATA_W-1:0] reg1_value,
    output logic [DATA_W-1:0] reg2_value,
    output logic [DATA_W-1:0] reg_return,
    output logic              busy,
    output logic              clr_done,
    output logic              wr_drop
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_INDEX);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              wr_drop_q;
    logic [DATA_W-1:0] regs_q [DEPTH];

    logic [ADDR_W-1:0] wr_idx;
    logic              wr_active;
    logic              zero_target;
    logic              wr_en;
    logic              bypass_en;

    // NOTE: every always_comb output gets a value before any branch so no latch is inferred.
    always_comb begin
        wr_idx = reg1_index;
        case (reg_write)
            2'b01:   wr_idx = LINK_IDX;
            2'b11:   wr_idx = reg2_index;
            default: wr_idx = reg1_index;
        endcase
    end

    assign wr_active   = (reg_write != 2'b00);
    assign zero_target = (ZERO_REG != 0) && (wr_idx == '0);
    assign wr_en       = wr_active && (state_q == S_IDLE) && !zero_target;
    // Forwarding is masked during reset so the read ports show the zeroed array.
    assign bypass_en   = (BYPASS != 0) && wr_en && !rst;

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= (state_q == S_CLEAR) && wr_active;
            case (state_q)
                S_IDLE: begin
                    if (clr_req) begin
                        state_q <= S_CLEAR;
                        ptr_q   <= '0;
                    end
                end
                S_CLEAR: begin
                    if (ptr_q == LAST_IDX) begin
                        state_q <= S_IDLE;
                        ptr_q   <= '0;
                    end else begin
                        ptr_q <= ptr_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    // NOTE: the array is reset because an asynchronous zero of every register is part of the contract;
    // this rules out a RAM macro and costs a reset net per flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (state_q == S_CLEAR) begin
            regs_q[ptr_q] <= '0;
        end else if (wr_en) begin
            regs_q[wr_idx] <= data_write;
        end
    end

    always_comb begin
        reg1_value = regs_q[reg1_index];
        reg2_value = regs_q[reg2_index];
        reg_return = regs_q[show_index];
        if (ZERO_REG != 0) begin
            if (reg1_index == '0) reg1_value = '0;
            if (reg2_index == '0) reg2_value = '0;
            if (show_index == '0) reg_return = '0;
        end
        if (bypass_en && (reg1_index == wr_idx)) reg1_value = data_write;
        if (bypass_en && (reg2_index == wr_idx)) reg2_value = data_write;
    end

    assign busy     = (state_q == S_CLEAR);
    assign clr_done = (state_q == S_CLEAR) && (ptr_q == LAST_IDX);
    assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_regfile_bypass.sv
// Scoreboard bench for regfile_bypass: the driver queues expected outputs per
// cycle, a negedge monitor pops and compares them against the DUT.
module tb_regfile_bypass;

    typedef enum int {S_R1, S_R2, S_RET, S_BUSY, S_DONE, S_DROP, S_R1B, S_R2B} sel_e;

    typedef struct {
        int          cyc;
        sel_e        sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  reg1_index, reg2_index, show_index;
    logic [1:0]  reg_write;
    logic [31:0] data_write;
    logic        clr_req;

    logic [31:0] r1, r2, ret, r1b, r2b, retb;
    logic        busy, done, drop, busyb, doneb, dropb;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Main DUT: zero register enabled, forwarding on.
    regfile_bypass #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .reg1_index(reg1_index), .reg2_index(reg2_index),
        .reg_write(reg_write), .data_write(data_write), .show_index(show_index),
        .clr_req(clr_req), .reg1_value(r1), .reg2_value(r2), .reg_return(ret),
        .busy(busy), .clr_done(done), .wr_drop(drop)
    );

    // Second DUT shares the stimulus but has forwarding disabled.
    regfile_bypass #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .reg1_index(reg1_index), .reg2_index(reg2_index),
        .reg_write(reg_write), .data_write(data_write), .show_index(show_index),
        .clr_req(clr_req), .reg1_value(r1b), .reg2_value(r2b), .reg_return(retb),
        .busy(busyb), .clr_done(doneb), .wr_drop(dropb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge clk) begin
        logic [31:0] act;
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            case (e.sel)
                S_R1:    act = r1;
                S_R2:    act = r2;
                S_RET:   act = ret;
                S_BUSY:  act = {31'd0, busy};
                S_DONE:  act = {31'd0, done};
                S_DROP:  act = {31'd0, drop};
                S_R1B:   act = r1b;
                S_R2B:   act = r2b;
                default: act = 'x;
            endcase
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
            end else if (act !== e.val) begin
                errors++;
                $display("FAIL %s: cycle %0d got %h expected %h", e.name, cyc, act, e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] m, input logic [4:0] i1, input logic [4:0] i2,
                         input logic [31:0] d, input logic [4:0] sh, input logic cr);
        reg_write  = m;
        reg1_index = i1;
        reg2_index = i2;
        data_write = d;
        show_index = sh;
        clr_req    = cr;
    endtask

    task automatic expect_val(input sel_e s, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc;
        e.sel  = s;
        e.val  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive(2'b00, 5'd0, 5'd0, 32'd0, 5'd0, 1'b0);

        // Reset state: outputs zero even with a write presented.
        tick();
        drive(2'b10, 5'd5, 5'd5, 32'hDEADBEEF, 5'd5, 1'b0);
        expect_val(S_R1, 32'd0, "rst_r1");
        expect_val(S_RET, 32'd0, "rst_ret");
        expect_val(S_BUSY, 32'd0, "rst_busy");
        expect_val(S_DONE, 32'd0, "rst_done");
        expect_val(S_DROP, 32'd0, "rst_drop");

        tick();
        rst = 1'b0;
        drive(2'b00, 5'd5, 5'd5, 32'd0, 5'd5, 1'b0);
        expect_val(S_RET, 32'd0, "rst_nowrite");

        // Mode 10 write with same-cycle bypass.
        tick();
        drive(2'b10, 5'd5, 5'd6, 32'hDEADBEEF, 5'd5, 1'b0);
        expect_val(S_R1, 32'hDEADBEEF, "byp_r1");
        expect_val(S_RET, 32'd0, "ret_not_bypassed");
        expect_val(S_R1B, 32'd0, "nobyp_r1_old");
        tick();
        drive(2'b00, 5'd5, 5'd6, 32'h0000FFFF, 5'd5, 1'b0);
        expect_val(S_RET, 32'hDEADBEEF, "ret_after_write");
        expect_val(S_R1, 32'hDEADBEEF, "mode00_no_bypass");

        // Mode 01 link write.
        tick();
        drive(2'b01, 5'd0, 5'd31, 32'h00001234, 5'd31, 1'b0);
        expect_val(S_R2, 32'h00001234, "link_bypass");
        tick();
        drive(2'b00, 5'd0, 5'd31, 32'd0, 5'd31, 1'b0);
        expect_val(S_RET, 32'h00001234, "link_stored");

        // Zero register write is discarded silently.
        tick();
        drive(2'b10, 5'd0, 5'd0, 32'hFFFFFFFF, 5'd0, 1'b0);
        expect_val(S_R1, 32'd0, "zero_r1_nobyp");
        expect_val(S_R2, 32'd0, "zero_r2_nobyp");
        tick();
        drive(2'b00, 5'd0, 5'd0, 32'd0, 5'd0, 1'b0);
        expect_val(S_DROP, 32'd0, "zero_no_drop");
        expect_val(S_RET, 32'd0, "zero_ret");
        expect_val(S_R1, 32'd0, "zero_r1");

        // Mode 11 forwards to both ports when indices match.
        tick();
        drive(2'b11, 5'd7, 5'd7, 32'h00000077, 5'd7, 1'b0);
        expect_val(S_R1, 32'h00000077, "m11_r1");
        expect_val(S_R2, 32'h00000077, "m11_r2");

        // Forwarding disabled: old value then new value.
        tick();
        drive(2'b10, 5'd3, 5'd4, 32'h11111111, 5'd3, 1'b0);
        expect_val(S_R1, 32'h11111111, "pre3_byp");
        expect_val(S_R1B, 32'd0, "pre3_nobyp");
        tick();
        drive(2'b10, 5'd3, 5'd3, 32'hA5A5A5A5, 5'd3, 1'b0);
        expect_val(S_R2B, 32'h11111111, "nobyp_old");
        expect_val(S_R2, 32'hA5A5A5A5, "byp_new");
        tick();
        drive(2'b00, 5'd3, 5'd3, 32'd0, 5'd3, 1'b0);
        expect_val(S_R2B, 32'hA5A5A5A5, "nobyp_new");

        // Fill every register, then read them all back.
        for (int i = 0; i < 32; i++) begin
            tick();
            drive(2'b10, 5'(i), 5'd0, 32'h100 + i, 5'd0, 1'b0);
        end
        for (int i = 0; i < 32; i++) begin
            tick();
            drive(2'b00, 5'd0, 5'd0, 32'd0, 5'(i), 1'b0);
            expect_val(S_RET, (i == 0) ? 32'd0 : 32'h100 + i, $sformatf("fill_%0d", i));
        end

        // Background clear: 32 busy cycles, a dropped write, an ignored re-request.
        tick();
        drive(2'b00, 5'd30, 5'd2, 32'd0, 5'd20, 1'b1);
        expect_val(S_BUSY, 32'd0, "clr_start_idle");
        for (int k = 1; k <= 33; k++) begin
            tick();
            drive(2'b00, 5'd30, 5'd2, 32'd0, 5'd20, (k == 4));
            if (k == 5) begin
                expect_val(S_R2, 32'd0, "mid_clr_cleared");
                expect_val(S_R1, 32'h11E, "mid_clr_uncleared");
            end
            if (k == 6) begin
                drive(2'b11, 5'd30, 5'd30, 32'h00000BAD, 5'd20, 1'b0);
                expect_val(S_R2, 32'h11E, "clr_no_bypass");
                expect_val(S_RET, 32'h114, "clr_ret_stored");
            end
            expect_val(S_BUSY, (k <= 32) ? 32'd1 : 32'd0, $sformatf("clr_busy_%0d", k));
            expect_val(S_DONE, (k == 32) ? 32'd1 : 32'd0, $sformatf("clr_done_%0d", k));
            expect_val(S_DROP, (k == 7) ? 32'd1 : 32'd0, $sformatf("clr_drop_%0d", k));
        end
        for (int i = 0; i < 32; i++) begin
            tick();
            drive(2'b00, 5'd0, 5'd0, 32'd0, 5'(i), 1'b0);
            expect_val(S_RET, 32'd0, $sformatf("cleared_%0d", i));
        end

        // Write coinciding with clr_req, then asynchronous reset at pointer 10.
        tick();
        drive(2'b10, 5'd20, 5'd0, 32'h00002020, 5'd0, 1'b0);
        tick();
        drive(2'b10, 5'd9, 5'd0, 32'h00000099, 5'd9, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            drive(2'b00, 5'd20, 5'd9, 32'd0, 5'd9, 1'b0);
            if (k == 1) expect_val(S_RET, 32'h99, "clr_write_done");
            if (k == 10) expect_val(S_RET, 32'h99, "clr_ptr9_pending");
            expect_val(S_BUSY, 32'd1, $sformatf("clr2_busy_%0d", k));
        end
        tick();
        drive(2'b00, 5'd20, 5'd20, 32'd0, 5'd20, 1'b0);
        rst = 1'b1;
        expect_val(S_R1, 32'd0, "arst_r1");
        expect_val(S_R2, 32'd0, "arst_r2");
        expect_val(S_RET, 32'd0, "arst_ret");
        expect_val(S_BUSY, 32'd0, "arst_busy");
        expect_val(S_DONE, 32'd0, "arst_done");
        expect_val(S_DROP, 32'd0, "arst_drop");
        tick();
        rst = 1'b0;
        drive(2'b00, 5'd20, 5'd9, 32'd0, 5'd9, 1'b0);
        expect_val(S_RET, 32'd0, "arst_reg9");
        expect_val(S_R1, 32'd0, "arst_reg20");
        for (int k = 0; k < 25; k++) begin
            tick();
            expect_val(S_BUSY, 32'd0, $sformatf("post_rst_busy_%0d", k));
            expect_val(S_DONE, 32'd0, $sformatf("post_rst_done_%0d", k));
        end

        tick();
        tick();
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: never compared, expected %h", e.name, e.val);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
